seq_detector_param: RTL and testbench
=====================================

Name: seq_detector_param

Overview:
- Parametrised serial sequence detector, successor to the fixed 4-bit "1011" Mealy detector.
- Pattern length set at build time; pattern value and overlap mode loaded at runtime.
- Input is a valid-qualified serial bit stream. Outputs are a registered one-cycle match pulse and a saturating match counter.
- Sits after a serial receiver/deserialiser front end and drives control logic or LED/status indicators.

Parameters:
- PAT_W, 4, pattern length in bits. Legal range 2..16.
- CNT_W, 8, width of the match counter.
- DEFAULT_PAT, 4'b1011, pattern register value after reset. Width PAT_W.
- DEFAULT_OVL, 1, overlap mode after reset. 1 = overlapping, 0 = non-overlapping.

Ports:
- clk  input  1  clock; all logic on posedge.
- rst  input  1  reset; synchronous, active-high.
- load  input  1  one-cycle strobe; latches pat_in and ovl_in.
- pat_in  input  PAT_W  new pattern; bit PAT_W-1 is the first bit received.
- ovl_in  input  1  new overlap mode.
- x  input  1  serial data bit.
- x_valid  input  1  x is sampled only on edges where x_valid=1.
- y  output  1  registered match pulse.
- match_cnt  output  CNT_W  number of matches since reset or load; saturates.
- armed  output  1  high when at least PAT_W - 1 valid bits are held, i.e. the next valid bit can complete a match.

Behaviour:
- Reset (rst=1 at posedge):
  - pattern reg = DEFAULT_PAT, ovl reg = DEFAULT_OVL.
  - history = 0, fill = 0, y = 0, match_cnt = 0, armed = 0.
  - rst takes priority over load and x_valid.
- Internal state:
  - history[PAT_W-1:0] shift register; shifts left, new bit enters at LSB.
  - fill counter, range 0..PAT_W, saturates at PAT_W.
- y default:
  - y is cleared every cycle unless set by a match.
  - y is never high for two consecutive cycles unless two consecutive valid bits each complete a match (possible only in overlap mode with periodic patterns).
- Load (load=1, rst=0):
  - pattern reg <= pat_in, ovl reg <= ovl_in.
  - history <= 0, fill <= 0, match_cnt <= 0, y <= 0.
  - Any x_valid on the same edge is dropped.
  - New pattern is active from the next edge.
- Valid bit (x_valid=1, no rst, no load):
  - next_hist = {history[PAT_W-2:0], x}.
  - Match condition: fill >= PAT_W-1 and next_hist == pattern reg.
  - On a match:
    - y <= 1 on this edge, so y is visible in the cycle after the completing bit (Mealy decision, registered output; latency 1).
    - match_cnt increments unless it is all ones (saturates, no wrap).
    - Overlap mode: history <= next_hist, fill stays saturated, so a suffix can begin the next match. Example: 1011011 gives 2 matches.
    - Non-overlap mode: history <= 0, fill <= 0, so the next match needs a full PAT_W fresh bits. Example: 1011011 gives 1 match.
  - No match: history <= next_hist, fill <= min(fill+1, PAT_W).
- x_valid=0: all state holds, y <= 0. Gaps between valid bits do not break a sequence.
- armed: combinational from the registered fill; armed = (fill >= PAT_W-1).
- Mid-stream load or rst: the partial sequence is discarded, and bits before the load never contribute to a match.

Optional Feature:
- Macro SEQ_DET_MASK_EN.
- Defined:
  - Adds port mask_in input PAT_W, latched on load. Reset value is all ones.
  - Pattern bits whose mask bit is 0 are don't-care.
  - Match condition becomes ((next_hist ^ pattern) & mask) == 0.
- Undefined:
  - No mask_in port, no mask register; every bit is compared exactly.

Test Plan:
- Reset defaults, overlap: after rst, valid bits 1,0,1,1 -> y=1 exactly one cycle after the 4th bit; match_cnt=1; armed=1 from after the 3rd bit.
- Overlap vs non-overlap: with default overlap, stream 1011011 -> 2 y pulses, match_cnt=2. Then load pat_in=4'b1011, ovl_in=0 and send 1011011 -> 1 pulse, match_cnt=1.
- Gaps and x_valid gating: bits 1,0,1,1 with x_valid=0 for 3 cycles between each bit, and x toggling randomly while invalid -> exactly 1 match, y only after the last valid bit.
- Load mid-stream: send 1,0,1; load pat_in=4'b0110 with x_valid=1, x=1 on the same edge; then send 0,1,1,0 -> x dropped on the load edge; 1 match on 0110; no match from pre-load bits.
- Saturation and reset priority: CNT_W=2, overlap, pattern 4'b1111, send 1 x10 -> match_cnt counts 1,2,3 and stays 3. Then assert rst with load=1 and x_valid=1 -> all outputs 0 and pattern back to 1011.
- SEQ_DET_MASK_EN build: load pat_in=4'b1001, mask_in=4'b1001, then send 1,1,0,1 -> match, y=1. Then send 0,1,1,1 (non-overlap, ovl_in=0) -> no match.

Source files
------------

// File: rtl/seq_detector_param.sv
// ---------------------------------------------------------------------------
// seq_detector_param
//
// Parametrised serial sequence detector. Watches a valid-qualified serial bit
// stream for a PAT_W-bit pattern that is loaded at runtime, together with an
// overlap/non-overlap mode. A match is decided on the edge that samples the
// completing bit and shows up on the registered y output one cycle later.
// Matches are tallied in a saturating counter.
//
// Optional build feature (macro SEQ_DET_MASK_EN):
//   adds a per-bit care mask loaded alongside the pattern; pattern bits whose
//   mask bit is 0 are ignored in the comparison. Without the macro every
//   pattern bit is compared exactly and there is no mask port.
//
// Parameters:
//   PAT_W        pattern length in bits (2..16)
//   CNT_W        width of the match counter
//   DEFAULT_PAT  pattern after reset
//   DEFAULT_OVL  overlap mode after reset (1 = overlapping)
//
// Ports:
//   clk        clock, everything on posedge
//   rst        synchronous active-high reset, wins over load and x_valid
//   load       one-cycle strobe latching pat_in / ovl_in (/ mask_in)
//   pat_in     new pattern, bit PAT_W-1 is the first bit received
//   ovl_in     new overlap mode
//   mask_in    new care mask (SEQ_DET_MASK_EN builds only)
//   x          serial data bit
//   x_valid    x is sampled only when this is high
//   y          registered one-cycle match pulse
//   match_cnt  matches since reset or load, saturating
//   armed      next valid bit can complete a match
// ---------------------------------------------------------------------------
module seq_detector_param #(
  parameter int               PAT_W       = 4,
  parameter int               CNT_W       = 8,
  parameter logic [PAT_W-1:0] DEFAULT_PAT = 4'b1011,
  parameter bit               DEFAULT_OVL = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [PAT_W-1:0] pat_in,
  input  logic             ovl_in,
`ifdef SEQ_DET_MASK_EN
  input  logic [PAT_W-1:0] mask_in,
`endif
  input  logic             x,
  input  logic             x_valid,
  output logic             y,
  output logic [CNT_W-1:0] match_cnt,
  output logic             armed
);

  // fill must be able to hold the value PAT_W itself
  localparam int FILL_W = $clog2(PAT_W + 1);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W);
  localparam logic [FILL_W-1:0] FILL_ARM  = FILL_W'(PAT_W - 1);

  logic [PAT_W-1:0]  pattern;
  logic              ovl;
  logic [PAT_W-1:0]  history;
  logic [FILL_W-1:0] fill;
  logic [PAT_W-1:0]  next_hist;
  logic [PAT_W-1:0]  diff;
  logic              hit;
`ifdef SEQ_DET_MASK_EN
  logic [PAT_W-1:0]  mask;
`endif

  // Match decision for the bit currently on x: the history as it would look
  // after shifting x in, compared against the pattern. Requiring PAT_W-1
  // bits already held keeps stale zeros in history from faking a match.
  always_comb begin
    next_hist = {history[PAT_W-2:0], x};
    diff      = next_hist ^ pattern;
`ifdef SEQ_DET_MASK_EN
    diff      = diff & mask;
`endif
    hit       = (fill >= FILL_ARM) && (diff == '0);
  end

  assign armed = (fill >= FILL_ARM);

  // Configuration, history, fill count, match pulse and counter. A load
  // restarts detection from scratch and swallows any bit on the same edge.
  // In non-overlap mode a match throws the history away so the next match
  // needs PAT_W fresh bits.
  always_ff @(posedge clk) begin
    if (rst) begin
      pattern   <= DEFAULT_PAT;
      ovl       <= DEFAULT_OVL;
`ifdef SEQ_DET_MASK_EN
      mask      <= '1;
`endif
      history   <= '0;
      fill      <= '0;
      y         <= 1'b0;
      match_cnt <= '0;
    end else if (load) begin
      pattern   <= pat_in;
      ovl       <= ovl_in;
`ifdef SEQ_DET_MASK_EN
      mask      <= mask_in;
`endif
      history   <= '0;
      fill      <= '0;
      y         <= 1'b0;
      match_cnt <= '0;
    end else begin
      y <= 1'b0;
      if (x_valid) begin
        if (hit) begin
          y <= 1'b1;
          if (match_cnt != '1) begin
            match_cnt <= match_cnt + 1'b1;
          end
          if (ovl) begin
            history <= next_hist;
            if (fill != FILL_FULL) begin
              fill <= fill + 1'b1;
            end
          end else begin
            history <= '0;
            fill    <= '0;
          end
        end else begin
          history <= next_hist;
          if (fill != FILL_FULL) begin
            fill <= fill + 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_seq_detector_param.sv
// ---------------------------------------------------------------------------
// tb_seq_detector_param
//
// Self-checking bench for seq_detector_param. Two instances share the same
// inputs: one with the default 8-bit counter and one with a 2-bit counter so
// that saturation can be exercised in a few bits. A small reference model,
// kept as a queue of the bits seen since the last restart, predicts y,
// match_cnt and armed for every step; predictions go into a scoreboard queue
// when the stimulus is driven and are popped after the clock edge.
// ---------------------------------------------------------------------------
module tb_seq_detector_param;

  logic       clk = 1'b0;
  logic       rst;
  logic       load;
  logic [3:0] pat_in;
  logic       ovl_in;
`ifdef SEQ_DET_MASK_EN
  logic [3:0] mask_in;
`endif
  logic       x;
  logic       x_valid;

  logic       y;
  logic [7:0] match_cnt;
  logic       armed;
  logic       y2;
  logic [1:0] match_cnt2;
  logic       armed2;

  always #5 clk = ~clk;

  seq_detector_param dut (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .pat_in    (pat_in),
    .ovl_in    (ovl_in),
`ifdef SEQ_DET_MASK_EN
    .mask_in   (mask_in),
`endif
    .x         (x),
    .x_valid   (x_valid),
    .y         (y),
    .match_cnt (match_cnt),
    .armed     (armed)
  );

  seq_detector_param #(.CNT_W(2)) dut_sat (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .pat_in    (pat_in),
    .ovl_in    (ovl_in),
`ifdef SEQ_DET_MASK_EN
    .mask_in   (mask_in),
`endif
    .x         (x),
    .x_valid   (x_valid),
    .y         (y2),
    .match_cnt (match_cnt2),
    .armed     (armed2)
  );

  typedef struct packed {
    logic       y;
    logic [7:0] cnt;
    logic [1:0] cnt2;
    logic       armed;
  } exp_t;

  exp_t sb_q[$];
  int   tests_run    = 0;
  int   tests_failed = 0;
  int   y_pulses     = 0;

  // reference model state
  logic [3:0] m_pat;
  logic [3:0] m_mask;
  logic       m_ovl;
  logic [7:0] m_cnt;
  logic [1:0] m_cnt2;
  bit         m_bits[$];

  // One comparison: counted, and reported on failure with tag and values.
  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Predict the outputs that will be visible after the coming edge.
  task automatic modelStep(input logic r, input logic ld, input logic [3:0] p,
                           input logic [3:0] m, input logic o, input logic xv,
                           input logic xb);
    exp_t e;
    bit   match;
    e.y = 1'b0;
    if (r) begin
      m_pat  = 4'b1011;
      m_mask = 4'hF;
      m_ovl  = 1'b1;
      m_cnt  = '0;
      m_cnt2 = '0;
      m_bits.delete();
    end else if (ld) begin
      m_pat  = p;
      m_mask = m;
      m_ovl  = o;
      m_cnt  = '0;
      m_cnt2 = '0;
      m_bits.delete();
    end else if (xv) begin
      m_bits.push_back(xb);
      if (m_bits.size() > 4) void'(m_bits.pop_front());
      if (m_bits.size() == 4) begin
        match = 1'b1;
        for (int i = 0; i < 4; i++) begin
          if (m_mask[3-i] && (m_bits[i] != m_pat[3-i])) match = 1'b0;
        end
        if (match) begin
          e.y = 1'b1;
          if (m_cnt != 8'hFF) m_cnt = m_cnt + 8'd1;
          if (m_cnt2 != 2'b11) m_cnt2 = m_cnt2 + 2'd1;
          if (!m_ovl) m_bits.delete();
        end
      end
    end
    e.cnt   = m_cnt;
    e.cnt2  = m_cnt2;
    e.armed = (m_bits.size() >= 3);
    sb_q.push_back(e);
  endtask

  // Pop the prediction for the edge just taken and compare both instances.
  task automatic checkOutput();
    exp_t e;
    tests_run++;
    assert (sb_q.size() != 0) else begin
      tests_failed++;
      $error("[TB] FAIL scoreboard: got empty queue expected an entry");
      return;
    end
    e = sb_q.pop_front();
    checkVal("y", 32'(y), 32'(e.y));
    checkVal("match_cnt", 32'(match_cnt), 32'(e.cnt));
    checkVal("armed", 32'(armed), 32'(e.armed));
    checkVal("y_sat", 32'(y2), 32'(e.y));
    checkVal("match_cnt_sat", 32'(match_cnt2), 32'(e.cnt2));
    checkVal("armed_sat", 32'(armed2), 32'(e.armed));
    if (y === 1'b1) y_pulses++;
  endtask

  // Drive one cycle of inputs away from the active edge, predict, then check.
  task automatic applyStimulus(input logic r, input logic ld, input logic [3:0] p,
                               input logic [3:0] m, input logic o, input logic xv,
                               input logic xb);
    @(negedge clk);
    rst     = r;
    load    = ld;
    pat_in  = p;
`ifdef SEQ_DET_MASK_EN
    mask_in = m;
`endif
    ovl_in  = o;
    x_valid = xv;
    x       = xb;
    modelStep(r, ld, p, m, o, xv, xb);
    @(posedge clk);
    #1;
    checkOutput();
  endtask

  task automatic sendBit(input logic b);
    applyStimulus(1'b0, 1'b0, 4'h0, 4'hF, 1'b0, 1'b1, b);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      applyStimulus(1'b0, 1'b0, 4'h0, 4'hF, 1'b0, 1'b0, 1'($urandom_range(0, 1)));
  endtask

  task automatic doReset();
    applyStimulus(1'b1, 1'b0, 4'h0, 4'hF, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic doLoad(input logic [3:0] p, input logic [3:0] m, input logic o);
    applyStimulus(1'b0, 1'b1, p, m, o, 1'b0, 1'b0);
  endtask

  initial begin
    logic [6:0] stream;
    rst     = 1'b1;
    load    = 1'b0;
    pat_in  = 4'h0;
    ovl_in  = 1'b0;
`ifdef SEQ_DET_MASK_EN
    mask_in = 4'hF;
`endif
    x       = 1'b0;
    x_valid = 1'b0;

    // reset defaults and the basic 1011 match
    doReset();
    checkVal("reset_cnt", 32'(match_cnt), 32'd0);
    checkVal("reset_armed", 32'(armed), 32'd0);
    sendBit(1'b1);
    sendBit(1'b0);
    checkVal("armed_after_2", 32'(armed), 32'd0);
    sendBit(1'b1);
    checkVal("armed_after_3", 32'(armed), 32'd1);
    checkVal("y_before_4th", 32'(y), 32'd0);
    sendBit(1'b1);
    checkVal("y_after_4th", 32'(y), 32'd1);
    checkVal("cnt_after_4th", 32'(match_cnt), 32'd1);
    idle(1);
    checkVal("y_drops", 32'(y), 32'd0);

    // overlapping: 1011011 gives two matches
    doReset();
    y_pulses = 0;
    stream = 7'b1011011;
    for (int i = 6; i >= 0; i--) sendBit(stream[i]);
    checkVal("ovl_pulses", 32'(y_pulses), 32'd2);
    checkVal("ovl_cnt", 32'(match_cnt), 32'd2);

    // non-overlapping: the same stream gives one match
    doLoad(4'b1011, 4'hF, 1'b0);
    y_pulses = 0;
    for (int i = 6; i >= 0; i--) sendBit(stream[i]);
    checkVal("novl_pulses", 32'(y_pulses), 32'd1);
    checkVal("novl_cnt", 32'(match_cnt), 32'd1);

    // gaps with x wiggling while invalid do not break the sequence
    doLoad(4'b1011, 4'hF, 1'b1);
    y_pulses = 0;
    sendBit(1'b1); idle(3);
    sendBit(1'b0); idle(3);
    sendBit(1'b1); idle(3);
    checkVal("gap_no_early_y", 32'(y_pulses), 32'd0);
    sendBit(1'b1);
    checkVal("gap_y_last", 32'(y), 32'd1);
    idle(3);
    checkVal("gap_pulses", 32'(y_pulses), 32'd1);

    // load mid-stream with a valid bit on the same edge: that bit is dropped
    sendBit(1'b1);
    sendBit(1'b0);
    sendBit(1'b1);
    applyStimulus(1'b0, 1'b1, 4'b0110, 4'hF, 1'b1, 1'b1, 1'b1);
    checkVal("load_armed", 32'(armed), 32'd0);
    checkVal("load_cnt", 32'(match_cnt), 32'd0);
    y_pulses = 0;
    sendBit(1'b0);
    sendBit(1'b1);
    sendBit(1'b1);
    sendBit(1'b0);
    checkVal("load_y", 32'(y), 32'd1);
    checkVal("load_pulses", 32'(y_pulses), 32'd1);

    // saturation of the 2-bit counter on pattern 1111
    doLoad(4'b1111, 4'hF, 1'b1);
    for (int i = 0; i < 10; i++) sendBit(1'b1);
    checkVal("sat_cnt2", 32'(match_cnt2), 32'd3);
    checkVal("sat_cnt8", 32'(match_cnt), 32'd7);

    // reset beats a simultaneous load and valid bit
    applyStimulus(1'b1, 1'b1, 4'b0000, 4'hF, 1'b0, 1'b1, 1'b1);
    checkVal("rstprio_y", 32'(y), 32'd0);
    checkVal("rstprio_cnt", 32'(match_cnt), 32'd0);
    checkVal("rstprio_armed", 32'(armed), 32'd0);
    sendBit(1'b1);
    sendBit(1'b0);
    sendBit(1'b1);
    sendBit(1'b1);
    checkVal("rstprio_pat_back", 32'(y), 32'd1);

`ifdef SEQ_DET_MASK_EN
    // middle two pattern bits are don't-care
    doLoad(4'b1001, 4'b1001, 1'b0);
    sendBit(1'b1);
    sendBit(1'b1);
    sendBit(1'b0);
    sendBit(1'b1);
    checkVal("mask_y", 32'(y), 32'd1);
    y_pulses = 0;
    sendBit(1'b0);
    sendBit(1'b1);
    sendBit(1'b1);
    sendBit(1'b1);
    checkVal("mask_nomatch", 32'(y_pulses), 32'd0);
`endif

    checkVal("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
